// File: rtl/tx_field_sequencer_if.sv
// tx_field_sequencer_if
// Payload-source and serial-output stream signals of the 802.11a TX field
// sequencer, bundled so the sequencer and its neighbours share one port.
//   src_data/src_vld/src_rdy : byte stream into the sequencer
//   dout/dout_vld/dout_rdy   : serial bit stream toward the encoder
//   dout_sig_flag            : bit belongs to the SIGNAL field
//   dout_rate_con            : latched rate code for the frame
//   dout_sym_end/dout_last   : last bit of an OFDM symbol / of the frame
// master = sequencer side, slave = environment side.
interface tx_field_sequencer_if;
    logic [7:0] src_data;
    logic       src_vld;
    logic       src_rdy;
    logic       dout;
    logic       dout_vld;
    logic       dout_rdy;
    logic       dout_sig_flag;
    logic [3:0] dout_rate_con;
    logic       dout_sym_end;
    logic       dout_last;

    modport master (
        input  src_data, src_vld, dout_rdy,
        output src_rdy, dout, dout_vld, dout_sig_flag, dout_rate_con,
               dout_sym_end, dout_last
    );

    modport slave (
        output src_data, src_vld, dout_rdy,
        input  src_rdy, dout, dout_vld, dout_sig_flag, dout_rate_con,
               dout_sym_end, dout_last
    );
endinterface

// File: rtl/tx_field_sequencer.sv
// tx_field_sequencer
// Builds the bit stream of one 802.11a PPDU: SIGNAL field (24 bits), SERVICE
// (16 zeros), DATA (payload bytes LSB first), TAIL (6 zeros) and PAD (zeros up
// to the end of the last OFDM symbol). Bits leave through a one-entry output
// register with a valid/ready handshake.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : frame request, sampled only while idle
//   rate, length   : rate code and PSDU length (bytes) for the requested frame
//   busy           : high whenever a frame is in progress
//   err            : one-cycle pulse after a rejected start
//   io (master)    : payload byte input and serial bit output with sideband
//
// The state/counters describe the NEXT bit to generate; the output register
// holds the bit currently offered downstream. A new bit is generated only
// when the output register can load (empty or being consumed).
module tx_field_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  rate,
    input  logic [11:0] length,
    output logic        busy,
    output logic        err,
    tx_field_sequencer_if.master io
);

    typedef enum logic [2:0] {IDLE, SIG, SERVICE, DATA, TAIL, PAD} state_t;

    state_t      state_q, state_d;
    logic [3:0]  rate_q, rate_d;
    logic [11:0] len_q, len_d;
    logic [4:0]  cnt_q, cnt_d;          // bit index within SIG/SERVICE/TAIL
    logic [7:0]  sym_cnt_q, sym_cnt_d;  // bit index within the OFDM symbol
    logic [11:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]  byte_q, byte_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        have_byte_q, have_byte_d;
    logic        fin_q, fin_d;          // final frame bit sits in the output register
    logic        err_q, err_d;
    logic        dout_q, dout_d;
    logic        dout_vld_q, dout_vld_d;
    logic        sig_flag_q, sig_flag_d;
    logic        sym_end_q, sym_end_d;
    logic        last_q, last_d;

    logic       load_en, gen, gbit, gsig, gsym, glast, sym_adv, sym_hit;
    logic       data_bit, src_rdy_c;
    logic [7:0] ndbps_m1;

    function automatic logic [7:0] ndbps(input logic [3:0] r);
        case (r)
            4'b1101: return 8'd24;
            4'b1111: return 8'd36;
            4'b0101: return 8'd48;
            4'b0111: return 8'd72;
            4'b1001: return 8'd96;
            4'b1011: return 8'd144;
            4'b0001: return 8'd192;
            4'b0011: return 8'd216;
            default: return 8'd24;
        endcase
    endfunction

    // SIGNAL bit idx: rate MSB first, reserved 0, length LSB first,
    // even parity over those 17 bits, then six zero tail bits.
    function automatic logic sig_bit(input logic [3:0] r, input logic [11:0] len,
                                     input logic [4:0] idx);
        logic [16:0] hdr;
        hdr = {len, 1'b0, r[0], r[1], r[2], r[3]};
        if (idx < 5'd17)       return hdr[idx];
        else if (idx == 5'd17) return ^hdr;
        else                   return 1'b0;
    endfunction

    always_comb begin
        state_d     = state_q;
        rate_d      = rate_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        sym_cnt_d   = sym_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        byte_d      = byte_q;
        bit_idx_d   = bit_idx_q;
        have_byte_d = have_byte_q;
        fin_d       = fin_q;
        err_d       = 1'b0;
        dout_d      = dout_q;
        dout_vld_d  = dout_vld_q;
        sig_flag_d  = sig_flag_q;
        sym_end_d   = sym_end_q;
        last_d      = last_q;
        gen         = 1'b0;
        gbit        = 1'b0;
        gsig        = 1'b0;
        gsym        = 1'b0;
        glast       = 1'b0;
        sym_adv     = 1'b0;
        src_rdy_c   = 1'b0;
        load_en     = !dout_vld_q || io.dout_rdy;
        ndbps_m1    = ndbps(rate_q) - 8'd1;
        sym_hit     = (sym_cnt_q == ndbps_m1);
        // A freshly handed-over byte is serialized from the bus directly.
        data_bit    = have_byte_q ? byte_q[bit_idx_q] : io.src_data[0];

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Every legal 802.11a rate code has rate[0]=1 and all eight
                    // such codes are legal, so rate[0] alone qualifies the rate.
                    if (rate[0] && (length != 12'd0)) begin
                        rate_d      = rate;
                        len_d       = length;
                        state_d     = SIG;
                        cnt_d       = 5'd1;
                        sym_cnt_d   = 8'd0;
                        byte_cnt_d  = 12'd0;
                        bit_idx_d   = 3'd0;
                        have_byte_d = 1'b0;
                        fin_d       = 1'b0;
                        // First SIG bit goes out straight from the request.
                        gen  = 1'b1;
                        gsig = 1'b1;
                        gbit = rate[3];
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SIG: begin
                if (load_en) begin
                    gen  = 1'b1;
                    gsig = 1'b1;
                    gbit = sig_bit(rate_q, len_q, cnt_q);
                    gsym = (cnt_q == 5'd23);
                    if (cnt_q == 5'd23) begin
                        state_d = SERVICE;
                        cnt_d   = 5'd0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            SERVICE: begin
                if (load_en) begin
                    gen     = 1'b1;
                    sym_adv = 1'b1;
                    if (cnt_q == 5'd15) begin
                        state_d = DATA;
                        cnt_d   = 5'd0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            DATA: begin
                src_rdy_c = !have_byte_q;
                if (src_rdy_c && io.src_vld) begin
                    byte_d      = io.src_data;
                    have_byte_d = 1'b1;
                    bit_idx_d   = 3'd0;
                end
                if (load_en && (have_byte_q || io.src_vld)) begin
                    gen     = 1'b1;
                    sym_adv = 1'b1;
                    gbit    = data_bit;
                    if (have_byte_q && (bit_idx_q == 3'd7)) begin
                        have_byte_d = 1'b0;
                        byte_cnt_d  = byte_cnt_q + 12'd1;
                        if (byte_cnt_q + 12'd1 == len_q) begin
                            state_d = TAIL;
                            cnt_d   = 5'd0;
                        end
                    end else begin
                        bit_idx_d = (have_byte_q ? bit_idx_q : 3'd0) + 3'd1;
                    end
                end
            end
            TAIL: begin
                if (load_en && !fin_q) begin
                    gen     = 1'b1;
                    sym_adv = 1'b1;
                    if (cnt_q == 5'd5) begin
                        if (sym_hit) glast = 1'b1;
                        else         state_d = PAD;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            PAD: begin
                if (load_en && !fin_q) begin
                    gen     = 1'b1;
                    sym_adv = 1'b1;
                    glast   = sym_hit;
                end
            end
            default: state_d = IDLE;
        endcase

        if (sym_adv) begin
            gsym      = sym_hit;
            sym_cnt_d = sym_hit ? 8'd0 : sym_cnt_q + 8'd1;
        end
        if (glast) fin_d = 1'b1;

        if (load_en) begin
            dout_vld_d = gen;
            dout_d     = gbit;
            sig_flag_d = gsig;
            sym_end_d  = gsym;
            last_d     = glast;
        end

        // The final bit is being consumed: frame done.
        if (fin_q && load_en) begin
            state_d = IDLE;
            fin_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rate_q      <= 4'd0;
            len_q       <= 12'd0;
            cnt_q       <= 5'd0;
            sym_cnt_q   <= 8'd0;
            byte_cnt_q  <= 12'd0;
            byte_q      <= 8'd0;
            bit_idx_q   <= 3'd0;
            have_byte_q <= 1'b0;
            fin_q       <= 1'b0;
            err_q       <= 1'b0;
            dout_q      <= 1'b0;
            dout_vld_q  <= 1'b0;
            sig_flag_q  <= 1'b0;
            sym_end_q   <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rate_q      <= rate_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            sym_cnt_q   <= sym_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            byte_q      <= byte_d;
            bit_idx_q   <= bit_idx_d;
            have_byte_q <= have_byte_d;
            fin_q       <= fin_d;
            err_q       <= err_d;
            dout_q      <= dout_d;
            dout_vld_q  <= dout_vld_d;
            sig_flag_q  <= sig_flag_d;
            sym_end_q   <= sym_end_d;
            last_q      <= last_d;
        end
    end

    assign busy             = (state_q != IDLE);
    assign err              = err_q;
    assign io.src_rdy       = src_rdy_c;
    assign io.dout          = dout_q;
    assign io.dout_vld      = dout_vld_q;
    assign io.dout_sig_flag = sig_flag_q;
    assign io.dout_rate_con = rate_q;
    assign io.dout_sym_end  = sym_end_q;
    assign io.dout_last     = last_q;

endmodule

// File: doc/tx_field_sequencer.md
TX_FIELD_SEQUENCER -- requirements
Module: tx_field_sequencer

Interface
REQ-001 SHALL have ports, one per line: name, direction, width, meaning.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  frame request pulse, sampled only in IDLE.
- rate  in  4  RATE code R1..R4 as rate[3:0].
- length  in  12  PSDU length in bytes.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse on a rejected start.
- src_data  in  8  payload byte.
- src_vld  in  1  payload byte valid.
- src_rdy  out  1  payload byte accepted when src_vld & src_rdy.
- dout  out  1  serial bit toward encoder/puncture chain.
- dout_vld  out  1  dout valid.
- dout_rdy  in  1  downstream ready.
- dout_sig_flag  out  1  high while dout belongs to the SIGNAL field.
- dout_rate_con  out  4  latched rate, constant for the whole frame.
- dout_sym_end  out  1  high on the last bit of each OFDM symbol.
- dout_last  out  1  high on the final bit of the frame.
REQ-002 SHALL have no parameters; all sizes are fixed by 802.11a.

Function
REQ-003 SHALL implement states IDLE, SIG, SERVICE, DATA, TAIL, PAD.
REQ-004 In IDLE, start SHALL be accepted only if rate is in {1101,1111,0101,0111,1001,1011,0001,0011} and length is nonzero.
- Accepted start: latch rate and length, go to SIG.
- Rejected start: pulse err the next cycle, stay in IDLE.
REQ-005 N_DBPS SHALL be looked up from the latched rate: 1101=24, 1111=36, 0101=48, 0111=72, 1001=96, 1011=144, 0001=192, 0011=216.
REQ-006 A bit SHALL be transferred when dout_vld & dout_rdy; the output register SHALL load a new bit only when !dout_vld | dout_rdy.
REQ-007 dout, dout_vld and all dout_* sideband SHALL hold stable while dout_vld & !dout_rdy.
REQ-008 SIG SHALL emit 24 bits with dout_sig_flag=1, in this order:
- rate[3], rate[2], rate[1], rate[0];
- reserved 0;
- length[0]..length[11] (LSB first);
- even parity over the preceding 17 bits;
- six 0 tail bits.
REQ-009 SERVICE SHALL emit 16 zero bits. DATA SHALL emit 8*length payload bits, each byte LSB first. TAIL SHALL emit 6 zero bits. All carry dout_sig_flag=0.
REQ-010 In DATA, src_rdy SHALL pulse for one cycle to fetch a byte only when the serializer is empty.
- If src_vld is low, dout_vld SHALL deassert; no bit may be dropped or duplicated.
- src_rdy SHALL be 0 in all other states.
REQ-011 A DATA-field bit counter SHALL count 0..N_DBPS-1 from the first SERVICE bit, wrapping to 0.
- dout_sym_end SHALL be 1 on count N_DBPS-1 and on SIG bit 23.
REQ-012 After TAIL, if the counter is nonzero, PAD SHALL emit zero bits until the bit with count N_DBPS-1. If the counter is 0, the frame ends at the last tail bit. No divider is used.
REQ-013 dout_last SHALL be 1 only on the final frame bit. After that bit transfers, the block SHALL return to IDLE.
- busy falls the cycle after the final transfer.
- start is accepted in the next IDLE cycle.
REQ-014 The first SIG bit SHALL present dout_vld=1 in the cycle after start is accepted; no idle gaps between fields unless back-pressure or source stall.
REQ-015 start while busy SHALL be ignored with no err.

Reset
REQ-016 On rst_n low, asynchronously:
- state=IDLE; all counters 0.
- busy, err, src_rdy, dout, dout_vld, dout_sig_flag, dout_sym_end, dout_last = 0.
- dout_rate_con=0000.
REQ-017 Reset mid-frame SHALL abort immediately; after release, the block SHALL accept a new start with no residue of the aborted frame.

Verification
REQ-018 rate=1101, length=1, src byte 0x01, dout_rdy=1 ->
- SIG = 1101 0 100000000000 0 000000 (parity 0).
- Then 48 DATA bits: 16 zeros, 1, 7 zeros, 6 tail, 18 pad.
- dout_sym_end on bits 23/47/71; dout_last on the 72nd bit.
REQ-019 rate=0011, length=100 -> 822 data+service+tail bits, then 42 pad bits.
- 4 symbols of 216 bits; 4 dout_sym_end pulses after SIG.
- dout_rate_con=0011 throughout.
REQ-020 Random dout_rdy low 50% during the REQ-018 frame -> identical bit sequence; outputs stable while stalled.
REQ-021 src_vld low for 10 cycles mid-DATA -> dout_vld low, resumes with the next correct bit, total bit count unchanged.
REQ-022 start with rate=0000 or length=0 -> err pulse for 1 cycle, busy stays 0, no dout_vld.
REQ-023 rst_n asserted at SIG bit 10 -> all outputs 0 immediately; a subsequent start produces a complete, correct frame.
